// File: rtl/des_mem_pkg.sv
// Shared constants and types for the DES plaintext block store.
// Geometry, key and streamer state encoding live here.
package des_mem_pkg;

  localparam int ROWS       = 133;
  localparam int COLS       = 200;
  localparam int DATA_WIDTH = 64;
  localparam int DEPTH      = (ROWS * COLS) / 8;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  localparam logic [DATA_WIDTH-1:0] KEY =
    64'h3031323334353637;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_e;

  // True when a block address points inside the array
  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a < ADDR_WIDTH'(DEPTH);
  endfunction

endpackage

// File: rtl/des_block_ram.sv
// Simple dual-port block RAM, one write and one registered read port.
// Read-first: a same-cycle write is not visible on the read port.
module des_block_ram #(
  parameter int DW    = 64,
  parameter int DEPTH = 3325,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array write and registered read share one edge so reads see old data
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/des_data_memory.sv
// Plaintext block store and streamer feeding the DES source.
// Load/read ports work only while idle; the streamer owns the RAM when busy.
module des_data_memory
  import des_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  start,
  output logic                  blk_valid_dout,
  output logic [DATA_WIDTH-1:0] blk_data_dout,
  output logic [DATA_WIDTH-1:0] blk_key_dout,
  input  logic                  blk_ready_din,
  output logic                  busy,
  output logic                  done
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic                  done_q, done_d;

  logic                  idle;
  logic                  hs;
  logic                  rd_req;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign idle = (state_q == IDLE);
  assign hs   = (state_q == PRESENT) && blk_ready_din;

  des_block_ram #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Streamer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Streamer next-state: fetch, present until accepted, repeat to last
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        state_d = PRESENT;
      end
      PRESENT: begin
        if (blk_ready_din) begin
          state_d = (addr_q == LAST_ADDR) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers: stream address, read tracking, done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_hold_q <= '0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      rd_hold_q <= rd_hold_d;
      done_q    <= done_d;
    end
  end

  // RAM arbitration and datapath next values
  always_comb begin
    addr_d = addr_q;
    if (idle && start) begin
      addr_d = '0;
    end else if (hs && (addr_q != LAST_ADDR)) begin
      addr_d = addr_q + 1'b1;
    end
    ram_we    = idle && wr_en && in_range(wr_addr);
    rd_req    = idle && rd_en && in_range(rd_addr);
    ram_re    = rd_req || (state_q == FETCH);
    ram_raddr = (state_q == FETCH) ? addr_q : rd_addr;
    rd_pend_d = rd_req;
    rd_hold_d = rd_pend_q ? ram_rdata : rd_hold_q;
    done_d    = (state_q == DONE);
  end

  // Output decode; RAM output is steady while a block is presented
  always_comb begin
    blk_valid_dout = (state_q == PRESENT);
    blk_data_dout  = blk_valid_dout ? ram_rdata : '0;
    blk_key_dout   = KEY;
    busy           = !idle;
    done           = done_q;
    rd_valid       = rd_pend_q;
    rd_data        = rd_pend_q ? ram_rdata : rd_hold_q;
  end

endmodule

// File: tb/tb_des_data_memory.sv
// Self-checking bench for des_data_memory.
// Reference model is a plain block array plus handshake bookkeeping.
module tb_des_data_memory;

  localparam int          DEPTH = 3325;
  localparam logic [63:0] KEY   = 64'h3031323334353637;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        start;
  logic        blk_valid_dout;
  logic [63:0] blk_data_dout;
  logic [63:0] blk_key_dout;
  logic        blk_ready_din;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [DEPTH];
  logic        exp_rd_v;
  logic [63:0] exp_rd_d;

  always #5 clk = ~clk;

  des_data_memory dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .start          (start),
    .blk_valid_dout (blk_valid_dout),
    .blk_data_dout  (blk_data_dout),
    .blk_key_dout   (blk_key_dout),
    .blk_ready_din  (blk_ready_din),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pick();
    if ($urandom_range(0, 7) == 0)
      return 12'($urandom_range(DEPTH - 4, 4095));
    return 12'($urandom_range(0, 15));
  endfunction

  // One idle-mode cycle: check read port, then drive load/read ports
  task automatic cyc_io(input logic        we,
                        input logic [11:0] wa,
                        input logic [63:0] wd,
                        input logic        re,
                        input logic [11:0] ra);
    @(negedge clk);
    chk("rd_valid", rd_valid, exp_rd_v);
    chk("rd_data", rd_data, exp_rd_d);
    chk("idle_busy", busy, 0);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    start   = 1'b0;
    if (re && ra < DEPTH) begin
      exp_rd_v = 1'b1;
      exp_rd_d = model[ra];
    end else begin
      exp_rd_v = 1'b0;
    end
    if (we && wa < DEPTH) model[wa] = wd;
  endtask

  // mode 0: ready high; 1: ready low 10 cycles at block 5; 2: random
  task automatic run_stream(input int mode,
                            input bit collide,
                            input int abort_at);
    int hs;
    int since;
    int bp;
    bit fin;
    bit ended;
    hs    = 0;
    since = 0;
    bp    = 0;
    fin   = 0;
    ended = 0;
    @(negedge clk);
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    blk_ready_din = 1'b0;
    start         = 1'b1;
    exp_rd_v      = 1'b0;
    for (int cyc = 0; cyc < 30000 && !ended; cyc++) begin
      bit ev;
      @(negedge clk);
      since++;
      start         = 1'b0;
      wr_en         = 1'b0;
      rd_en         = 1'b0;
      blk_ready_din = 1'b0;
      ev = !fin && since >= 2;
      chk("blk_valid", blk_valid_dout, ev);
      if (ev)
        chk($sformatf("blk_data[%0d]", hs), blk_data_dout, model[hs]);
      chk("blk_key", blk_key_dout, KEY);
      chk("busy", busy, !(fin && since >= 2));
      chk("done", done, fin && since == 2);
      chk("rd_valid_busy", rd_valid, 0);
      chk("rd_data_busy", rd_data, exp_rd_d);
      if (fin && since == 2) begin
        ended = 1;
      end else if (ev && hs == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_valid", blk_valid_dout, 0);
        chk("abort_data", blk_data_dout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_key", blk_key_dout, KEY);
        chk("abort_rd_data", rd_data, 0);
        exp_rd_d = '0;
        @(negedge clk);
        chk("abort_held_done", done, 0);
        reset = 1'b0;
        return;
      end else begin
        if (mode == 0) begin
          blk_ready_din = 1'b1;
        end else if (mode == 1) begin
          if (ev && hs == 5 && bp < 10) begin
            blk_ready_din = 1'b0;
            bp++;
          end else begin
            blk_ready_din = 1'b1;
          end
        end else begin
          blk_ready_din = 1'($urandom_range(0, 1));
        end
        if (collide) begin
          wr_en   = 1'($urandom_range(0, 1));
          wr_addr = ($urandom_range(0, 1) == 1) ? 12'd7 : pick();
          wr_data = {$urandom, $urandom};
          rd_en   = 1'($urandom_range(0, 1));
          rd_addr = pick();
          start   = 1'($urandom_range(0, 1));
        end
        if (ev && blk_ready_din) begin
          hs++;
          since = 0;
          if (hs == DEPTH) fin = 1;
        end
      end
    end
    chk("stream_complete", ended, 1);
    chk("handshakes", hs, DEPTH);
    if (mode == 1) chk("backpressure_cycles", bp, 10);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    reset         = 1'b1;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    start         = 1'b0;
    blk_ready_din = 1'b0;
    exp_rd_v      = 1'b0;
    exp_rd_d      = '0;

    repeat (2) @(negedge clk);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_blk_valid", blk_valid_dout, 0);
    chk("rst_blk_data", blk_data_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_key", blk_key_dout, KEY);
    reset = 1'b0;

    cyc_io(1, 12'd0, 64'h6D656D6F72696573, 0, 12'd0);
    cyc_io(0, 12'd0, 64'h0, 1, 12'd0);
    cyc_io(0, 12'd0, 64'h0, 0, 12'd0);
    cyc_io(1, 12'd3324, 64'hFFFF_0000_FFFF_0000, 0, 12'd0);
    cyc_io(0, 12'd0, 64'h0, 1, 12'd3324);
    cyc_io(1, 12'd0, 64'hAAAA_5555_1234_5678, 1, 12'd0);
    cyc_io(0, 12'd0, 64'h0, 1, 12'd0);
    cyc_io(1, 12'd3325, 64'hDEAD_BEEF_0000_0001, 1, 12'd3325);
    cyc_io(0, 12'd0, 64'h0, 1, 12'd4095);
    cyc_io(0, 12'd0, 64'h0, 1, 12'd3324);
    cyc_io(0, 12'd0, 64'h0, 0, 12'd0);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_blk_valid", blk_valid_dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_key", blk_key_dout, KEY);
    exp_rd_v = 1'b0;
    exp_rd_d = '0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      cyc_io(1, 12'(i), 64'(i), 0, 12'd0);
    cyc_io(0, 12'd0, 64'h0, 0, 12'd0);

    run_stream(0, 0, -1);

    repeat (300)
      cyc_io(1'($urandom_range(0, 1)), pick(), {$urandom, $urandom},
             1'($urandom_range(0, 1)), pick());
    cyc_io(0, 12'd0, 64'h0, 0, 12'd0);

    run_stream(1, 0, -1);

    run_stream(2, 1, -1);
    cyc_io(0, 12'd0, 64'h0, 1, 12'd7);
    cyc_io(0, 12'd0, 64'h0, 0, 12'd0);

    run_stream(0, 0, 100);
    cyc_io(0, 12'd0, 64'h0, 0, 12'd0);
    run_stream(0, 0, -1);
    cyc_io(0, 12'd0, 64'h0, 1, 12'd5);
    cyc_io(0, 12'd0, 64'h0, 0, 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
